// File: rtl/uart_8250_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_8250_tx
//  Description : Transmit path of an 8250-compatible UART. It holds the THR
//                or the TX FIFO and the serialiser that drives TXD.
//                Ports:
//                  CLK_I, RST_I (async, active-low)      clock / reset
//                  baud_tick_i                           OVERSAMPLE x baud pulse
//                  thr_wr_i, thr_data_i                  THR write strobe / byte
//                  fifo_en_i, fifo_clr_i                 FCR[0], FCR[2] pulse
//                  lcr_i[6:0]                            WLS, STB, PEN, EPS, stick, break
//                  txd_o                                 serial out, idle high
//                  thre_o, temt_o                        LSR status
//                  fifo_level_o                          entries held
//                  wr_drop_o                             write discarded (full)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_8250_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       baud_tick_i,
  input  logic       thr_wr_i,
  input  logic [7:0] thr_data_i,
  input  logic       fifo_en_i,
  input  logic       fifo_clr_i,
  input  logic [6:0] lcr_i,
  output logic       txd_o,
  output logic       thre_o,
  output logic       temt_o,
  output logic [4:0] fifo_level_o,
  output logic       wr_drop_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam logic [TW-1:0] BIT_LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'((OVERSAMPLE * 3) / 2 - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);
  localparam logic [4:0]    DEPTH5      = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // FIFO / holding register
  // --------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    level_q, level_d;
  logic          fifo_en_q;
  logic          wr_drop_q;
  logic          flush, full, push, pop;
  logic [4:0]    cap;
  state_t        state_q, state_d;

  // Toggling FIFO mode empties the queue, exactly like an explicit clear.
  assign flush = fifo_clr_i | (fifo_en_i ^ fifo_en_q);
  assign cap   = fifo_en_i ? DEPTH5 : 5'd1;
  assign full  = (level_q >= cap);
  assign pop   = (state_q == S_IDLE) && (level_q != 5'd0) && !flush;
  // A pop in the same cycle frees a slot, so a write at full still lands.
  assign push  = thr_wr_i && !flush && (!full || pop);

  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = 5'd0;
    end else if (push && !pop) begin
      level_d = level_q + 5'd1;
    end else if (pop && !push) begin
      level_d = level_q - 5'd1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push) begin
      mem_q[wr_ptr_q] <= thr_data_i;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= 5'd0;
      fifo_en_q <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      fifo_en_q <= fifo_en_i;
      level_q   <= level_d;
      wr_drop_q <= thr_wr_i && !flush && full && !pop;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Serialiser
  // --------------------------------------------------------------------------
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [1:0]    wls_q, wls_d;
  logic          stb_q, stb_d;
  logic          pen_q, pen_d;
  logic          tx_bit;
  logic          bit_end;
  logic [TW-1:0] bit_last;
  logic [7:0]    head_masked;

  // Bits above the word length are zeroed so they neither shift out nor
  // affect parity.
  assign head_masked = mem_q[rd_ptr_q] & (8'hFF >> (2'd3 - lcr_i[1:0]));

  always_comb begin
    bit_last = BIT_LAST;
    if (state_q == S_STOP && stb_q) begin
      bit_last = (wls_q == 2'd0) ? STOP15_LAST : STOP2_LAST;
    end
  end

  assign bit_end = baud_tick_i && (state_q != S_IDLE) && (tick_q == bit_last);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    wls_d   = wls_q;
    stb_d   = stb_q;
    pen_d   = pen_q;
    tx_bit  = 1'b1;

    if (state_q != S_IDLE && baud_tick_i) begin
      tick_d = bit_end ? '0 : tick_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = head_masked;
          wls_d   = lcr_i[1:0];
          stb_d   = lcr_i[2];
          pen_d   = lcr_i[3];
          // stick parity forces ~EPS; otherwise EPS=1 even, EPS=0 odd
          par_d   = lcr_i[5] ? ~lcr_i[4] : (lcr_i[4] ? ^head_masked : ~^head_masked);
          tick_d  = '0;
          bit_d   = 3'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_bit = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx_bit = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == (3'd4 + {1'b0, wls_q})) begin
            state_d = pen_q ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        tx_bit = par_q;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        tx_bit = 1'b1;
        if (bit_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      wls_q   <= 2'd0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      wls_q   <= wls_d;
      stb_q   <= stb_d;
      pen_q   <= pen_d;
    end
  end

  // Break acts on the live LCR bit, independent of the frame in progress.
  assign txd_o        = tx_bit & ~lcr_i[6];
  assign thre_o       = (level_q == 5'd0);
  assign temt_o       = thre_o && (state_q == S_IDLE);
  assign fifo_level_o = level_q;
  assign wr_drop_o    = wr_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_8250_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_8250_tx
//  Description : Scoreboard bench for uart_8250_tx. Accepted THR writes push
//                (byte, LCR) into a queue; a monitor decodes TXD per baud tick
//                and compares each frame to a waveform built from the UART
//                framing rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_8250_tx;

  localparam int OS    = 16;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [7:0] d;
    logic [6:0] lcr;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       thr_wr = 1'b0;
  logic [7:0] thr_data = 8'h00;
  logic       fifo_en = 1'b0;
  logic       fifo_clr = 1'b0;
  logic [6:0] lcr = 7'h03;
  logic       txd, thre, temt, wr_drop;
  logic [4:0] level;

  int     total = 0;
  int     bad = 0;
  int     drop_cnt = 0;
  int     tcnt = 0;
  bit     tick_en = 1'b0;
  bit     mon_en = 1'b1;
  frame_t sb[$];

  bit           m_in_frame = 1'b0;
  bit           m_junk = 1'b0;
  int           m_n = 0;
  int           m_len = 0;
  logic [191:0] m_got, m_exp;
  frame_t       m_f;

  uart_8250_tx #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
    .CLK_I        (clk),
    .RST_I        (rst_n),
    .baud_tick_i  (baud_tick),
    .thr_wr_i     (thr_wr),
    .thr_data_i   (thr_data),
    .fifo_en_i    (fifo_en),
    .fifo_clr_i   (fifo_clr),
    .lcr_i        (lcr),
    .txd_o        (txd),
    .thre_o       (thre),
    .temt_o       (temt),
    .fifo_level_o (level),
    .wr_drop_o    (wr_drop)
  );

  always #5 clk = ~clk;

  // Baud tick: one cycle in four while enabled.
  initial begin : tick_gen
    forever begin
      @(posedge clk);
      #1;
      tcnt = (tcnt + 1) % 4;
      baud_tick = tick_en && (tcnt == 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [7:0] d, input bit accepted);
    frame_t f;
    f.d = d;
    f.lcr = lcr;
    thr_wr = 1'b1;
    thr_data = d;
    if (accepted) sb.push_back(f);
    step();
    thr_wr = 1'b0;
  endtask

  // Reference frame: list of (level, duration) from the framing rules, then
  // expanded into one sample per baud tick.
  function automatic void build_frame(input frame_t f, output int len, output logic [191:0] v);
    int vals[$];
    int durs[$];
    int nbits, ones, p, idx;
    nbits = int'(f.lcr[1:0]) + 5;
    ones = 0;
    vals.push_back(0); durs.push_back(OS);
    for (int i = 0; i < nbits; i++) begin
      vals.push_back((f.d >> i) & 1);
      durs.push_back(OS);
      ones += (f.d >> i) & 1;
    end
    if (f.lcr[3]) begin
      if (f.lcr[5])      p = f.lcr[4] ? 0 : 1;
      else if (f.lcr[4]) p = ones % 2;
      else               p = 1 - (ones % 2);
      vals.push_back(p); durs.push_back(OS);
    end
    vals.push_back(1);
    if (!f.lcr[2])              durs.push_back(OS);
    else if (f.lcr[1:0] == 2'd0) durs.push_back(OS * 3 / 2);
    else                         durs.push_back(2 * OS);
    v = '0;
    idx = 0;
    foreach (vals[k]) begin
      for (int t = 0; t < durs[k]; t++) begin
        v[idx] = vals[k][0];
        idx++;
      end
    end
    len = idx;
  endfunction

  // Monitor: a low TXD while idle starts a frame; TXD is sampled once per tick.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (wr_drop) drop_cnt++;
      if (!mon_en) begin
        m_in_frame = 1'b0;
        m_junk = 1'b0;
      end else begin
        if (m_junk && txd) m_junk = 1'b0;
        if (!m_in_frame && !m_junk && txd == 1'b0) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got start bit want idle line");
            m_junk = 1'b1;
          end else begin
            m_f = sb.pop_front();
            build_frame(m_f, m_len, m_exp);
            m_got = '0;
            m_n = 0;
            m_in_frame = 1'b1;
          end
        end
        if (m_in_frame && baud_tick) begin
          m_got[m_n] = txd;
          m_n++;
          if (m_n == m_len) begin
            m_in_frame = 1'b0;
            total++;
            if (m_got !== m_exp) begin
              bad++;
              $display("FAIL frame d=%02h lcr=%02h: got %h want %h", m_f.d, m_f.lcr, m_got, m_exp);
            end
          end
        end
      end
    end
  end

  // Counts baud ticks from the start bit until temt rises; temt must rise on
  // the cycle right after the final stop tick.
  task automatic measure_frame(input string nm, input int exp_ticks);
    int ticks = 0;
    bit started = 1'b0;
    bit prev_tick = 1'b0;
    bit done = 1'b0;
    for (int c = 0; c < 6000 && !done; c++) begin
      @(negedge clk);
      if (!started && txd == 1'b0) started = 1'b1;
      if (started) begin
        if (temt) done = 1'b1;
        else begin
          ticks += int'(baud_tick);
          prev_tick = baud_tick;
        end
      end
    end
    if (!done) fail({nm, "_temt"});
    chk({nm, "_ticks"}, ticks, exp_ticks);
    chk({nm, "_temt_edge"}, {31'd0, prev_tick}, 1);
  endtask

  task automatic wait_sb(input int n, input string nm);
    int c = 0;
    while (sb.size() > n && c < 30000) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (sb.size() > n) fail(nm);
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while (!temt && c < 6000) begin
      @(negedge clk);
      c++;
    end
    if (!temt) fail(nm);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d0;
    bit nen;
    logic [6:0] nlcr;
    int n, cap, guard;

    // ---------------- reset ----------------
    steps(3);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_thre", thre, 1);
    chk("rst_temt", temt, 1);
    chk("rst_level", level, 0);
    chk("rst_drop", wr_drop, 0);

    // ---------------- 8N1 0x55 ----------------
    step();
    tick_en = 1'b1;
    lcr = 7'h03;
    wr(8'h55, 1'b1);
    @(negedge clk);
    chk("thre_fall", thre, 0);
    chk("level_one", level, 1);
    measure_frame("8n1", 160);

    // ---------------- 7E2 0x41 ----------------
    step();
    lcr = 7'h1E;
    wr(8'h41, 1'b1);
    measure_frame("7e2", 176);

    // ---------------- 5O1.5 0x1F, LCR changed mid-frame ----------------
    step();
    lcr = 7'h0C;
    wr(8'h1F, 1'b1);
    fork
      measure_frame("5o15", 136);
      begin
        steps(60);
        lcr = 7'h03;
      end
    join

    // ---------------- FIFO fill with ticks held off ----------------
    step();
    tick_en = 1'b0;
    fifo_en = 1'b1;
    steps(3);
    d0 = drop_cnt;
    // first byte moves straight into the shifter, so 17 writes leave 16 queued
    for (int i = 0; i < 17; i++) wr(8'($urandom), 1'b1);
    @(negedge clk);
    chk("fifo_level16", level, 16);
    chk("fifo_no_drop", drop_cnt - d0, 0);
    step();
    wr(8'hEE, 1'b0);
    @(negedge clk);
    chk("fifo_drop_pulse", wr_drop, 1);
    chk("fifo_level_full", level, 16);
    step();
    @(negedge clk);
    chk("fifo_drop_clear", wr_drop, 0);
    chk("fifo_drop_count", drop_cnt - d0, 1);
    step();
    tick_en = 1'b1;
    wait_sb(1, "fifo_drain1");
    chk("thre_before_last_pop", thre, 0);
    wait_sb(0, "fifo_drain0");
    chk("thre_after_last_pop", thre, 1);
    chk("level_after_last_pop", level, 0);
    wait_idle("fifo_idle");

    // ---------------- non-FIFO back-to-back ----------------
    step();
    fifo_en = 1'b0;
    steps(3);
    d0 = drop_cnt;
    wr(8'hA1, 1'b1);
    wr(8'hA2, 1'b1);
    wr(8'hA3, 1'b0);
    @(negedge clk);
    chk("thr_drop_pulse", wr_drop, 1);
    chk("thr_level", level, 1);
    chk("thr_drop_count", drop_cnt - d0, 1);
    wait_sb(0, "thr_drain");
    wait_idle("thr_idle");

    // ---------------- clear mid-frame, clear beats write ----------------
    step();
    fifo_en = 1'b1;
    tick_en = 1'b0;
    steps(3);
    for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i), 1'b1);
    fork
      measure_frame("clr_frame", 160);
      begin
        tick_en = 1'b1;
        steps(100);
        fifo_clr = 1'b1;
        thr_wr = 1'b1;
        thr_data = 8'h99;
        step();
        fifo_clr = 1'b0;
        thr_wr = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("clr_level", level, 0);
      end
    join
    steps(800);
    @(negedge clk);
    chk("clr_temt", temt, 1);
    chk("clr_level_end", level, 0);

    // ---------------- break ----------------
    step();
    mon_en = 1'b0;
    lcr = 7'h43;
    #1;
    chk("break_low", txd, 0);
    step();
    lcr = 7'h03;
    #1;
    chk("break_release", txd, 1);
    steps(2);
    mon_en = 1'b1;

    // ---------------- reset mid-DATA ----------------
    step();
    for (int i = 0; i < 3; i++) wr(8'h30 + 8'(i), 1'b1);
    steps(160);
    mon_en = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_txd", txd, 1);
    chk("arst_level", level, 0);
    chk("arst_thre", thre, 1);
    chk("arst_temt", temt, 1);
    sb.delete();
    steps(2);
    rst_n = 1'b1;
    steps(3);
    mon_en = 1'b1;

    // ---------------- randomized batches ----------------
    d0 = drop_cnt;
    for (int b = 0; b < 5; b++) begin
      nen = 1'($urandom_range(0, 1));
      nlcr = 7'($urandom_range(0, 63));
      wait_sb(0, "rnd_batch_drain");
      step();
      if (nen != fifo_en) begin
        wait_idle("rnd_mode_idle");
        step();
        fifo_en = nen;
        steps(2);
      end
      // the frame still shifting keeps the LCR it was started with
      lcr = nlcr;
      n = $urandom_range(3, 6);
      for (int k = 0; k < n; k++) begin
        cap = fifo_en ? DEPTH : 1;
        guard = 0;
        while (sb.size() >= cap && guard < 5000) begin
          step();
          guard++;
        end
        if (sb.size() >= cap) fail("rnd_room");
        steps($urandom_range(0, 3));
        wr(8'($urandom), 1'b1);
      end
    end
    wait_sb(0, "rnd_final_drain");
    wait_idle("rnd_final_idle");
    chk("rnd_no_drops", drop_cnt - d0, 0);
    chk("rnd_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
